multiplicador_nb: RTL and testbench
===================================

MULTIPLICADOR_NB -- requirements
Module: multiplicador_nb

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous and active-high.
REQ-002 Parameter WIDTH SHALL default to 8; it is the operand width, a multiple of 4, from 4 to 32.
REQ-003 Derived constant K SHALL equal WIDTH/4, the digit count per operand.
REQ-004 CLK  input  1  SHALL be the clock; all state updates occur on its rising edge.
REQ-005 RST  input  1  SHALL be the asynchronous active-high reset.
REQ-006 START  input  1  SHALL be the request to begin one multiplication; it is sampled only in IDLE.
REQ-007 SIGNED_MODE  input  1  SHALL select the mode, sampled with START: 1 = two's-complement, 0 = unsigned.
REQ-008 A, B  input  WIDTH  SHALL be the operands, sampled with START.
REQ-009 BUSY  output  1  SHALL be 1 while a multiplication is in progress (states MUL and FIN).
REQ-010 DONE  output  1  SHALL be a one-cycle pulse that marks RES as updated.
REQ-011 RES  output  2*WIDTH  SHALL be the registered product, held until the next completion.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, MUL, FIN.
REQ-013 In IDLE with START=1 at an edge, the block SHALL perform all of the following:
- capture |A| and |B| into internal WIDTH-bit registers (magnitude taken only if SIGNED_MODE=1);
- capture sign = A[msb] XOR B[msb] (forced 0 when unsigned);
- clear the 2*WIDTH accumulator and the digit counter;
- go to MUL.
REQ-014 MUL SHALL last exactly K*K cycles; each cycle handles one digit pair (i,j), with j iterating fastest:
- form the 8-bit product of digit i of |A| and digit j of |B| using the ROM sub-module;
- add that product, shifted left by 4*(i+j), to the accumulator;
- after the last pair, go to FIN.
REQ-015 FIN SHALL do the following in one cycle, then return to IDLE:
- write RES as the accumulator, negated modulo 2^(2*WIDTH) if sign=1;
- set DONE=1.
REQ-016 Latency SHALL be fixed: RES and DONE update on edge K*K+1 after the START-sampling edge (edge 0).
- WIDTH=8: edge 5.
- WIDTH=16: edge 17.
REQ-017 DONE SHALL be high for exactly one cycle and SHALL be 0 at all other times.
REQ-018 START while BUSY=1 SHALL be ignored, with no effect on operands, mode or timing.
REQ-019 START=1 in the cycle DONE=1 (state IDLE) SHALL be accepted, so back-to-back operations have no bubble.
REQ-020 Signed magnitude of the most negative value (-2^(WIDTH-1)) SHALL be 2^(WIDTH-1) unsigned, with no overflow.
REQ-021 The product SHALL be exact for all operand pairs in both modes; no truncation or saturation.
REQ-022 Operand changes on A, B or SIGNED_MODE after capture SHALL NOT affect the running operation.

Reset
REQ-023 RST=1 SHALL immediately force the following, regardless of state or clock:
- state IDLE;
- BUSY=0, DONE=0, RES=0;
- accumulator, counter and operand registers cleared.
REQ-024 Reset during MUL or FIN SHALL abort the operation with no DONE pulse; the first START after RST falls SHALL start a fresh operation.

Structure
REQ-025 Shared package mult_pkg SHALL hold the state encoding (IDLE, MUL, FIN) and constant DIGIT_W=4.
REQ-026 A single sub-module rom_mult4 SHALL provide the combinational 4x4 -> 8-bit unsigned product table; multiplicador_nb SHALL instantiate it once.
REQ-027 The adder and negator SHALL be inline in multiplicador_nb; no external ALU instance.

Verification
REQ-028 WIDTH=8, unsigned, A=255, B=255 -> edge 5: RES=0xFE01, DONE=1 for 1 cycle; BUSY=1 on edges 1-4.
REQ-029 WIDTH=8, signed, the bench SHALL check both cases:
- A=0xFD (-3), B=5 -> RES=0xFFF1;
- A=0x80, B=0x80 -> RES=0x4000.
REQ-030 WIDTH=16, unsigned, A=0xFFFF, B=0xFFFF -> edge 17: RES=0xFFFE0001.
REQ-031 WIDTH=8, start 12*13, then pulse START with 1*1 at edge 2 -> edge 5: RES=156 (0x009C); second START ignored.
REQ-032 WIDTH=8, START 7*9, RST=1 at edge 3, START 2*3 after reset -> no DONE for the first operation; RES=0 after reset; RES=6 five edges after the new START.
REQ-033 WIDTH=8, START 10*10, START 4*4 in the DONE cycle -> RES=100 then RES=16 five edges later; DONE pulses twice.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the nibble-serial multiplier.
// State encoding and digit width.
package mult_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/rom_mult4.sv
// 4x4 -> 8-bit unsigned product table.
// Purely combinational; one digit pair per lookup.
module rom_mult4
  import mult_pkg::*;
(
  input  logic [DIGIT_W-1:0]   a_i,
  input  logic [DIGIT_W-1:0]   b_i,
  output logic [2*DIGIT_W-1:0] p_o
);

  // Table lookup expressed as a narrow product.
  always_comb begin
    p_o = {4'b0, a_i} * {4'b0, b_i};
  end

endmodule

// File: rtl/multiplicador_nb.sv
// Sequential multiplier: one nibble pair per cycle.
// Signed mode works on magnitudes and fixes the sign at the end.
module multiplicador_nb
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               SIGNED_MODE,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               BUSY,
  output logic               DONE,
  output logic [2*WIDTH-1:0] RES
);

  localparam int K     = WIDTH / DIGIT_W;
  localparam int IW    = (K > 1) ? $clog2(K) : 1;
  localparam int ACC_W = 2 * WIDTH;
  localparam logic [IW-1:0] LAST = IW'(K - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sign_q, sign_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [IW-1:0]      i_q, i_d;
  logic [IW-1:0]      j_q, j_d;
  logic [ACC_W-1:0]   res_q, res_d;
  logic               done_q, done_d;

  logic [DIGIT_W-1:0]   dig_a;
  logic [DIGIT_W-1:0]   dig_b;
  logic [2*DIGIT_W-1:0] pp;
  logic [ACC_W-1:0]     term;

  assign dig_a = a_q[DIGIT_W*i_q +: DIGIT_W];
  assign dig_b = b_q[DIGIT_W*j_q +: DIGIT_W];

  rom_mult4 u_rom (
    .a_i (dig_a),
    .b_i (dig_b),
    .p_o (pp)
  );

  // Align the partial product to digit position i+j.
  always_comb begin
    term = ACC_W'(pp) << (DIGIT_W * (int'(i_q) + int'(j_q)));
  end

  // Next-state and datapath updates for IDLE/MUL/FIN.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    acc_d   = acc_q;
    i_d     = i_q;
    j_d     = j_q;
    res_d   = res_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          a_d = (SIGNED_MODE && A[WIDTH-1]) ? -A : A;
          b_d = (SIGNED_MODE && B[WIDTH-1]) ? -B : B;
          sign_d  = SIGNED_MODE & (A[WIDTH-1] ^ B[WIDTH-1]);
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d = acc_q + term;
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            state_d = FIN;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      FIN: begin
        res_d   = sign_q ? -acc_q : acc_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared by async reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      j_q     <= j_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign BUSY = (state_q != IDLE);
  assign DONE = done_q;
  assign RES  = res_q;

endmodule

// File: tb/tb_multiplicador_nb.sv
// Self-checking bench for multiplicador_nb.
// Covers WIDTH=8 and WIDTH=16 instances.
module tb_multiplicador_nb;

  logic        CLK;
  logic        RST;

  logic        s8, sm8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] res8;

  logic        s16, sm16;
  logic [15:0] a16, b16;
  logic        busy16, done16;
  logic [31:0] res16;

  int checks;
  int failures;

  multiplicador_nb #(.WIDTH(8)) dut8 (
    .CLK         (CLK),
    .RST         (RST),
    .START       (s8),
    .SIGNED_MODE (sm8),
    .A           (a8),
    .B           (b8),
    .BUSY        (busy8),
    .DONE        (done8),
    .RES         (res8)
  );

  multiplicador_nb #(.WIDTH(16)) dut16 (
    .CLK         (CLK),
    .RST         (RST),
    .START       (s16),
    .SIGNED_MODE (sm16),
    .A           (a16),
    .B           (b16),
    .BUSY        (busy16),
    .DONE        (done16),
    .RES         (res16)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sm;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] ref8(input logic [7:0] a,
                                       input logic [7:0] b,
                                       input logic sm);
    int x, y;
    x = sm ? int'($signed(a)) : int'(a);
    y = sm ? int'($signed(b)) : int'(b);
    return 16'(x * y);
  endfunction

  function automatic logic [31:0] ref16(input logic [15:0] a,
                                        input logic [15:0] b,
                                        input logic sm);
    longint x, y;
    x = sm ? longint'($signed(a)) : longint'(a);
    y = sm ? longint'($signed(b)) : longint'(b);
    return 32'(x * y);
  endfunction

  // Called just after a falling edge; returns just after the
  // falling edge that follows the completion edge (DONE high).
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic sm, input logic [15:0] exp,
                     input string nm);
    logic bad;
    s8 = 1'b1; a8 = a; b8 = b; sm8 = sm;
    @(negedge CLK);
    s8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    sm8 = ~sm;
    bad = (busy8 !== 1'b1) || (done8 !== 1'b0);
    for (int e = 1; e <= 4; e++) begin
      @(negedge CLK);
      if (busy8 !== 1'b1 || done8 !== 1'b0) bad = 1'b1;
    end
    chk({nm, "_busy"}, 64'(bad), 64'd0);
    @(negedge CLK);
    chk({nm, "_done"}, 64'(done8), 64'd1);
    chk({nm, "_res"}, 64'(res8), 64'(exp));
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b,
                      input logic sm, input logic [31:0] exp,
                      input string nm);
    logic bad;
    s16 = 1'b1; a16 = a; b16 = b; sm16 = sm;
    @(negedge CLK);
    s16 = 1'b0;
    a16 = 16'($urandom);
    b16 = 16'($urandom);
    bad = (busy16 !== 1'b1) || (done16 !== 1'b0);
    for (int e = 1; e <= 16; e++) begin
      @(negedge CLK);
      if (busy16 !== 1'b1 || done16 !== 1'b0) bad = 1'b1;
    end
    chk({nm, "_busy"}, 64'(bad), 64'd0);
    @(negedge CLK);
    chk({nm, "_done"}, 64'(done16), 64'd1);
    chk({nm, "_res"}, 64'(res16), 64'(exp));
    @(negedge CLK);
    chk({nm, "_done_drop"}, 64'(done16), 64'd0);
  endtask

  initial begin
    logic [7:0]  ra, rb;
    logic [15:0] wa, wb;
    logic        rs;
    logic        seen;

    checks = 0;
    failures = 0;
    RST = 1'b1;
    s8 = 0; sm8 = 0; a8 = 0; b8 = 0;
    s16 = 0; sm16 = 0; a16 = 0; b16 = 0;

    #3;
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_done8", 64'(done8), 64'd0);
    chk("rst_res8", 64'(res8), 64'd0);
    chk("rst_res16", 64'(res16), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    vecs.push_back('{8'd255, 8'd255, 1'b0, 16'hFE01});
    vecs.push_back('{8'hFD, 8'd5, 1'b1, 16'hFFF1});
    vecs.push_back('{8'h80, 8'h80, 1'b1, 16'h4000});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 16'h4000});
    vecs.push_back('{8'h7F, 8'h80, 1'b1, 16'hC080});
    vecs.push_back('{8'h80, 8'h7F, 1'b0, 16'h3F80});
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 16'h0001});
    vecs.push_back('{8'h80, 8'h01, 1'b1, 16'hFF80});
    vecs.push_back('{8'h00, 8'hFF, 1'b1, 16'h0000});
    vecs.push_back('{8'h12, 8'h34, 1'b0, 16'h03A8});

    foreach (vecs[k]) begin
      op8(vecs[k].a, vecs[k].b, vecs[k].sm, vecs[k].exp,
          $sformatf("vec%0d", k));
      @(negedge CLK);
      chk($sformatf("vec%0d_done_drop", k), 64'(done8), 64'd0);
    end

    for (int n = 0; n < 30; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom_range(0, 1));
      op8(ra, rb, rs, ref8(ra, rb, rs), $sformatf("rnd%0d", n));
      @(negedge CLK);
    end

    op16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "w16_max");
    op16(16'h8000, 16'h8000, 1'b1, 32'h40000000, "w16_minneg");
    for (int n = 0; n < 6; n++) begin
      wa = 16'($urandom);
      wb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      op16(wa, wb, rs, ref16(wa, wb, rs), $sformatf("w16rnd%0d", n));
    end

    // START while busy is ignored
    s8 = 1'b1; a8 = 8'd12; b8 = 8'd13; sm8 = 1'b0;
    @(negedge CLK);
    s8 = 1'b0;
    @(negedge CLK);
    s8 = 1'b1; a8 = 8'd1; b8 = 8'd1;
    @(negedge CLK);
    s8 = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("ign_busy", 64'(busy8), 64'd1);
    @(negedge CLK);
    chk("ign_done", 64'(done8), 64'd1);
    chk("ign_res", 64'(res8), 64'd156);
    seen = 1'b0;
    repeat (8) begin
      @(negedge CLK);
      if (done8 !== 1'b0 || busy8 !== 1'b0) seen = 1'b1;
    end
    chk("ign_no_second", 64'(seen), 64'd0);

    // Reset aborts a running operation
    s8 = 1'b1; a8 = 8'd7; b8 = 8'd9;
    @(negedge CLK);
    s8 = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("abort_busy", 64'(busy8), 64'd0);
    chk("abort_res", 64'(res8), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge CLK);
      if (done8 !== 1'b0) seen = 1'b1;
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    chk("abort_res_hold", 64'(res8), 64'd0);
    op8(8'd2, 8'd3, 1'b0, 16'd6, "after_rst");
    @(negedge CLK);

    // Back-to-back: new START in the DONE cycle
    op8(8'd10, 8'd10, 1'b0, 16'd100, "b2b_first");
    op8(8'd4, 8'd4, 1'b0, 16'd16, "b2b_second");
    @(negedge CLK);
    chk("b2b_done_drop", 64'(done8), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
